// File: rtl/btn_ctrl.sv
// Five-button debouncer with a memory-mapped STATE/STATUS/MASK block and a level interrupt.
// Optional feature macro: BTN_IRQ_EN (MASK register and irq_btn); without it irq_btn is tied low.
module btn_ctrl #(
    parameter int          DEB_CNT   = 50000,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F078
) (
    input  logic        clk_to_btn,
    input  logic        rst_n_to_btn,
    input  logic [31:0] addr_to_btn,
    input  logic        we_to_btn,
    input  logic [31:0] wdata_to_btn,
    output logic [31:0] rdata_from_btn,
    input  logic [4:0]  button,
    output logic        irq_btn
);

    localparam logic [19:0] CNT_MAX     = 20'(DEB_CNT - 1);
    localparam logic [31:0] ADDR_STATE  = BASE_ADDR;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_MASK   = BASE_ADDR + 32'd8;

    logic [4:0]  r_meta;
    logic [4:0]  r_sync;
    logic [4:0]  r_stb;
    logic [4:0]  r_sts;
    logic [19:0] r_cnt [5];
    logic [4:0]  w_done;
    logic [4:0]  w_rise;
    logic [4:0]  w_clr;
    logic [4:0]  w_mask;

    // Debounce completion and press detection per button
    always_comb begin
        w_done = 5'd0;
        w_rise = 5'd0;
        for (int i = 0; i < 5; i++) begin
            w_done[i] = (r_sync[i] != r_stb[i]) && (r_cnt[i] == CNT_MAX);
            w_rise[i] = w_done[i] & r_sync[i];
        end
    end

    // STATUS write-one-to-clear mask for this edge
    always_comb begin
        if (we_to_btn && (addr_to_btn == ADDR_STATUS)) begin
            w_clr = wdata_to_btn[4:0];
        end else begin
            w_clr = 5'd0;
        end
    end

    // Two-flop synchronizer on the raw buttons
    always_ff @(posedge clk_to_btn or negedge rst_n_to_btn) begin
        if (!rst_n_to_btn) begin
            r_meta <= 5'd0;
            r_sync <= 5'd0;
        end else begin
            r_meta <= button;
            r_sync <= r_meta;
        end
    end

    // Per-bit stability counter; the counter resets on acceptance so it never wraps
    always_ff @(posedge clk_to_btn or negedge rst_n_to_btn) begin
        if (!rst_n_to_btn) begin
            r_stb <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= 20'd0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (r_sync[i] == r_stb[i]) begin
                    r_cnt[i] <= 20'd0;
                end else if (w_done[i]) begin
                    r_cnt[i] <= 20'd0;
                    r_stb[i] <= r_sync[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 20'd1;
                end
            end
        end
    end

    // Sticky press status; a new press wins over a simultaneous clear
    always_ff @(posedge clk_to_btn or negedge rst_n_to_btn) begin
        if (!rst_n_to_btn) begin
            r_sts <= 5'd0;
        end else begin
            r_sts <= (r_sts & ~w_clr) | w_rise;
        end
    end

`ifdef BTN_IRQ_EN
    logic [4:0] r_mask;
    logic       r_irq;

    // MASK register write
    always_ff @(posedge clk_to_btn or negedge rst_n_to_btn) begin
        if (!rst_n_to_btn) begin
            r_mask <= 5'd0;
        end else if (we_to_btn && (addr_to_btn == ADDR_MASK)) begin
            r_mask <= wdata_to_btn[4:0];
        end else begin
            r_mask <= r_mask;
        end
    end

    // Interrupt follows the masked status one edge later
    always_ff @(posedge clk_to_btn or negedge rst_n_to_btn) begin
        if (!rst_n_to_btn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_sts & r_mask);
        end
    end

    assign w_mask  = r_mask;
    assign irq_btn = r_irq;
`else
    assign w_mask  = 5'd0;
    assign irq_btn = 1'b0;
`endif

    // Zero-latency read mux over a full 32-bit address match
    always_comb begin
        rdata_from_btn = 32'd0;
        case (addr_to_btn)
            ADDR_STATE:  rdata_from_btn = {27'd0, r_stb};
            ADDR_STATUS: rdata_from_btn = {27'd0, r_sts};
            ADDR_MASK:   rdata_from_btn = {27'd0, w_mask};
            default:     rdata_from_btn = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with DEB_CNT=4; MASK/irq expectations follow BTN_IRQ_EN.
module tb_btn_ctrl;

    localparam logic [31:0] A_STATE  = 32'hFFFF_F078;
    localparam logic [31:0] A_STATUS = 32'hFFFF_F07C;
    localparam logic [31:0] A_MASK   = 32'hFFFF_F080;

`ifdef BTN_IRQ_EN
    localparam logic       IRQ_ON = 1'b1;
`else
    localparam logic       IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  button;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    btn_ctrl #(.DEB_CNT(4), .BASE_ADDR(32'hFFFF_F078)) dut (
        .clk_to_btn     (clk),
        .rst_n_to_btn   (rst_n),
        .addr_to_btn    (addr),
        .we_to_btn      (we),
        .wdata_to_btn   (wdata),
        .rdata_from_btn (rdata),
        .button         (button),
        .irq_btn        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    initial begin
        rst_n  = 1'b0;
        addr   = A_STATE;
        we     = 1'b0;
        wdata  = 32'd0;
        button = 5'h1F;
        #2;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk_rd("rst_state", A_STATE, 32'd0);
        chk_rd("rst_status", A_STATUS, 32'd0);
        tick(2);
        chk_rd("rst_hold_state", A_STATE, 32'd0);
        button = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Steady press on button[0]: accepted on the 6th sampling edge
        button = 5'b00001;
        tick(5);
        chk_rd("press_edge5_state", A_STATE, 32'd0);
        tick(1);
        chk_rd("press_edge6_state", A_STATE, 32'd1);
        chk_rd("press_edge6_status", A_STATUS, 32'd1);
        button = 5'd0;
        tick(6);
        chk_rd("release_state", A_STATE, 32'd0);
        chk_rd("release_status_kept", A_STATUS, 32'd1);
        wr(A_STATUS, 32'h1);
        chk_rd("w1c_status", A_STATUS, 32'd0);

        // Short glitch on button[2]
        button = 5'b00100;
        tick(3);
        button = 5'd0;
        tick(8);
        chk_rd("glitch_state", A_STATE, 32'd0);
        chk_rd("glitch_status", A_STATUS, 32'd0);

        // Masked interrupt on button[0]
        wr(A_MASK, 32'h1);
        chk_rd("mask_read", A_MASK, IRQ_ON ? 32'h1 : 32'h0);
        button = 5'b00001;
        tick(6);
        chk_rd("irq_sts_set", A_STATUS, 32'd1);
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        tick(1);
        chk("irq_high", {31'd0, irq}, {31'd0, IRQ_ON});
        wr(A_STATUS, 32'h1);
        chk_rd("irq_sts_clr", A_STATUS, 32'd0);
        chk("irq_lag", {31'd0, irq}, {31'd0, IRQ_ON});
        tick(1);
        chk("irq_low", {31'd0, irq}, 32'd0);
        button = 5'd0;
        tick(6);
        chk_rd("irq_release_state", A_STATE, 32'd0);

        // Clear on the same edge as button[1] acceptance: set wins
        button = 5'b00010;
        tick(5);
        wr(A_STATUS, 32'h2);
        chk_rd("setwins_status", A_STATUS, 32'd2);
        tick(1);
        chk("setwins_irq_masked", {31'd0, irq}, 32'd0);

        // Unmapped read and write to read-only STATE
        chk_rd("unmapped_read", 32'hFFFF_F084, 32'd0);
        wr(A_STATE, 32'h1F);
        chk_rd("state_ro", A_STATE, 32'd2);
        chk_rd("state_ro_status", A_STATUS, 32'd2);
        wr(32'hFFFF_F07D, 32'h2);
        chk_rd("near_addr_ignored", A_STATUS, 32'd2);

        // Reset in the middle of a button[3] debounce
        button = 5'b01000;
        wr(A_MASK, 32'h3);
        tick(3);
        chk("pre_rst_irq", {31'd0, irq}, {31'd0, IRQ_ON});
        chk_rd("pre_rst_state", A_STATE, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk_rd("mid_rst_state", A_STATE, 32'd0);
        chk_rd("mid_rst_status", A_STATUS, 32'd0);
        chk_rd("mid_rst_mask", A_MASK, 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk_rd("post_rst_edge5", A_STATE, 32'd0);
        tick(1);
        chk_rd("post_rst_edge6_state", A_STATE, 32'd8);
        chk_rd("post_rst_edge6_status", A_STATUS, 32'd8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
